// File: rtl/maze_controller_if.sv
// ============================================================================
// Module   : maze_controller_if
// Purpose  : Control/status bundle between the maze search controller (master)
//            and the maze datapath (slave): position, counter, stack, list, memory.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface maze_controller_if;
    // datapath status
    logic blocked;
    logic finish;
    logic empty_stack;
    logic Co;
    logic complete_read;
    logic dir_x;            // direction counter bit0: selects X axis when 1

    // controller strobes
    logic init_x;
    logic init_y;
    logic ld_x;
    logic ld_y;
    logic r_update;
    logic init_count;
    logic ld_count;
    logic en_count;
    logic init_stack;
    logic stack_dir_push;
    logic stack_dir_pop;
    logic init_list;
    logic list_push;
    logic en_read;
    logic maze_wr;

    modport master (
        input  blocked, finish, empty_stack, Co, complete_read, dir_x,
        output init_x, init_y, ld_x, ld_y, r_update, init_count, ld_count,
               en_count, init_stack, stack_dir_push, stack_dir_pop,
               init_list, list_push, en_read, maze_wr
    );

    modport slave (
        output blocked, finish, empty_stack, Co, complete_read, dir_x,
        input  init_x, init_y, ld_x, ld_y, r_update, init_count, ld_count,
               en_count, init_stack, stack_dir_push, stack_dir_pop,
               init_list, list_push, en_read, maze_wr
    );
endinterface

`default_nettype wire

// File: rtl/maze_controller.sv
// ============================================================================
// Module   : maze_controller
// Purpose  : Depth-first rat-in-maze search FSM over a 16x16 grid, then replays
//            the stored path as Move codes. Option: MAZE_CTRL_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module maze_controller #(
    parameter int MAX_STEPS = 1024,
    parameter int STEP_W    = 11
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    maze_controller_if.master dp,
    output logic              move_valid,
    output logic              busy,
    output logic              done,
    output logic              fail
`ifdef MAZE_CTRL_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    if ((2 ** STEP_W) <= MAX_STEPS) begin : g_step_w_check
        $error("STEP_W too narrow for MAX_STEPS");
    end

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_INIT  = 4'd1,
        S_CHECK = 4'd2,
        S_MOVE  = 4'd3,
        S_MARK  = 4'd4,
        S_BACK  = 4'd5,
        S_UNDO  = 4'd6,
        S_ADV   = 4'd7,
        S_PATH  = 4'd8,
        S_READ  = 4'd9,
        S_DONE  = 4'd10,
        S_FAIL  = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_busy;
    logic   r_done;
    logic   r_fail;
    logic   w_tmo;

`ifdef MAZE_CTRL_TIMEOUT_EN
    logic              w_search;
    logic [STEP_W-1:0] r_steps;
    logic              r_timeout;

    assign w_search = (r_state inside {S_CHECK, S_MOVE, S_MARK, S_BACK, S_UNDO, S_ADV});
    assign w_tmo    = w_search && (r_steps >= STEP_W'(MAX_STEPS));
    assign timeout  = r_timeout;
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_INIT;
            S_INIT:  w_next = S_CHECK;
            S_CHECK: begin
                if (dp.finish)           w_next = S_PATH;
                else if (!dp.blocked)    w_next = S_MOVE;
                else if (!dp.Co)         w_next = S_CHECK;
                else if (dp.empty_stack) w_next = S_FAIL;
                else                     w_next = S_BACK;
            end
            S_MOVE:  w_next = S_MARK;
            S_MARK:  w_next = S_CHECK;
            S_BACK:  w_next = S_UNDO;
            S_UNDO:  w_next = S_ADV;
            S_ADV: begin
                if (!dp.Co)              w_next = S_CHECK;
                else if (dp.empty_stack) w_next = S_FAIL;
                else                     w_next = S_BACK;
            end
            S_PATH:  if (dp.empty_stack)   w_next = S_READ;
            S_READ:  if (dp.complete_read) w_next = S_DONE;
            S_DONE,
            S_FAIL:  if (!start) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_tmo) w_next = S_FAIL;
    end

    // Strobes are Mealy: the datapath must act in the same cycle the decision is made.
    always_comb begin
        dp.init_x         = 1'b0;
        dp.init_y         = 1'b0;
        dp.ld_x           = 1'b0;
        dp.ld_y           = 1'b0;
        dp.r_update       = 1'b0;
        dp.init_count     = 1'b0;
        dp.ld_count       = 1'b0;
        dp.en_count       = 1'b0;
        dp.init_stack     = 1'b0;
        dp.stack_dir_push = 1'b0;
        dp.stack_dir_pop  = 1'b0;
        dp.init_list      = 1'b0;
        dp.list_push      = 1'b0;
        dp.en_read        = 1'b0;
        dp.maze_wr        = 1'b0;
        move_valid        = 1'b0;
        if (!w_tmo) begin
            case (r_state)
                S_INIT: begin
                    dp.init_x     = 1'b1;
                    dp.init_y     = 1'b1;
                    dp.init_count = 1'b1;
                    dp.init_stack = 1'b1;
                    dp.init_list  = 1'b1;
                    dp.maze_wr    = 1'b1;
                end
                S_CHECK: dp.en_count = !dp.finish && dp.blocked && !dp.Co;
                S_MOVE: begin
                    dp.ld_x           = dp.dir_x;
                    dp.ld_y           = !dp.dir_x;
                    dp.stack_dir_push = 1'b1;
                    dp.init_count     = 1'b1;
                end
                S_MARK:  dp.maze_wr = 1'b1;
                S_BACK: begin
                    dp.stack_dir_pop = 1'b1;
                    dp.ld_count      = 1'b1;
                end
                S_UNDO: begin
                    dp.ld_x     = dp.dir_x;
                    dp.ld_y     = !dp.dir_x;
                    dp.r_update = 1'b1;
                end
                S_ADV:   dp.en_count = !dp.Co;
                S_PATH: begin
                    dp.list_push     = !dp.empty_stack;
                    dp.stack_dir_pop = !dp.empty_stack;
                end
                S_READ: begin
                    dp.en_read = 1'b1;
                    move_valid = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_fail  <= 1'b0;
`ifdef MAZE_CTRL_TIMEOUT_EN
            r_steps   <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_busy  <= !(w_next inside {S_IDLE, S_DONE, S_FAIL});
            r_done  <= (w_next == S_DONE);
            r_fail  <= (w_next == S_FAIL);
`ifdef MAZE_CTRL_TIMEOUT_EN
            if (r_state == S_INIT)
                r_steps <= '0;
            else if ((r_state inside {S_MOVE, S_UNDO}) && !w_tmo)
                r_steps <= r_steps + 1'b1;
            if (w_tmo)
                r_timeout <= 1'b1;
            else if (w_next == S_IDLE)
                r_timeout <= 1'b0;
`endif
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign fail = r_fail;

endmodule

`default_nettype wire

// File: tb/tb_maze_controller.sv
// ============================================================================
// Module   : tb_maze_controller
// Purpose  : Bench for maze_controller with a behavioural maze datapath and a
//            Move-code scoreboard. Honours MAZE_CTRL_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_maze_controller;

`ifdef MAZE_CTRL_TIMEOUT_EN
    localparam int C_MAX_STEPS = 8;
    localparam int C_STEP_W    = 4;
    logic timeout;
`else
    localparam int C_MAX_STEPS = 1024;
    localparam int C_STEP_W    = 11;
`endif

    logic CLK   = 1'b0;
    logic RST   = 1'b0;
    logic start = 1'b0;
    logic move_valid, busy, done, fail;

    maze_controller_if dp_if ();

    maze_controller #(.MAX_STEPS(C_MAX_STEPS), .STEP_W(C_STEP_W)) u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .dp         (dp_if.master),
        .move_valid (move_valid),
        .busy       (busy),
        .done       (done),
        .fail       (fail)
`ifdef MAZE_CTRL_TIMEOUT_EN
        ,
        .timeout    (timeout)
`endif
    );

    always #5 CLK = ~CLK;

    // behavioural datapath: dir 0:+Y 1:+X 2:-Y 3:-X
    bit         wall [16][16];
    bit         all_blocked = 1'b0;
    bit         m_vis [16][16];
    int         m_x = 0, m_y = 0, m_sp = 0, m_lsz = 0, m_rd = 0;
    logic [1:0] m_cnt = 2'd0;
    logic [1:0] m_stk [256];
    logic [1:0] m_lst [512];
    logic [7:0] w_top;
    int         w_nx, w_ny;
    logic       w_blk;

    function automatic int dstep(input logic [1:0] c, input logic rev);
        int d;
        d = c[1] ? -1 : 1;
        return rev ? -d : d;
    endfunction

    assign w_top = 8'(m_sp - 1);

    always_comb begin
        w_nx = m_x;
        w_ny = m_y;
        if (m_cnt[0]) w_nx = m_x + dstep(m_cnt, 1'b0);
        else          w_ny = m_y + dstep(m_cnt, 1'b0);
        w_blk = all_blocked || w_nx < 0 || w_nx > 15 || w_ny < 0 || w_ny > 15;
        if (!w_blk) w_blk = wall[w_nx[3:0]][w_ny[3:0]] || m_vis[w_nx[3:0]][w_ny[3:0]];
    end

    assign dp_if.blocked       = w_blk;
    assign dp_if.finish        = (m_x == 15) && (m_y == 15);
    assign dp_if.empty_stack   = (m_sp == 0);
    assign dp_if.Co            = (m_cnt == 2'd3);
    assign dp_if.complete_read = (m_rd + 1 >= m_lsz);
    assign dp_if.dir_x         = m_cnt[0];

    always @(posedge CLK) begin
        if (dp_if.init_x)    m_x <= 0;
        else if (dp_if.ld_x) m_x <= m_x + dstep(m_cnt, dp_if.r_update);
        if (dp_if.init_y)    m_y <= 0;
        else if (dp_if.ld_y) m_y <= m_y + dstep(m_cnt, dp_if.r_update);
        if (dp_if.init_count)    m_cnt <= 2'd0;
        else if (dp_if.ld_count) m_cnt <= m_stk[w_top];
        else if (dp_if.en_count) m_cnt <= m_cnt + 2'd1;
        if (dp_if.init_stack) m_sp <= 0;
        else if (dp_if.stack_dir_push) begin
            m_stk[m_sp[7:0]] <= m_cnt;
            m_sp <= m_sp + 1;
        end else if (dp_if.stack_dir_pop) m_sp <= m_sp - 1;
        if (dp_if.init_list) begin
            m_lsz <= 0;
            m_rd  <= 0;
        end else begin
            if (dp_if.list_push) begin
                m_lst[m_lsz[8:0]] <= m_stk[w_top];
                m_lsz <= m_lsz + 1;
            end
            if (dp_if.en_read) m_rd <= m_rd + 1;
        end
        if (dp_if.init_x) begin
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++)
                    m_vis[i][j] <= 1'b0;
            m_vis[0][0] <= 1'b1;
        end else if (dp_if.maze_wr) m_vis[m_x[3:0]][m_y[3:0]] <= 1'b1;
    end

    // checking
    int n_checks = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    logic [1:0] exp_q [$];
    logic       clr_stats = 1'b0;
    int n_push, n_push_pre, n_back, n_undo_rev, n_en, n_mv, n_viol;

    always @(negedge CLK) begin
        if (clr_stats) begin
            n_push = 0; n_push_pre = 0; n_back = 0; n_undo_rev = 0;
            n_en = 0; n_mv = 0; n_viol = 0;
        end else begin
            if (dp_if.stack_dir_push) begin
                n_push++;
                if (n_back == 0) n_push_pre++;
            end
            if (dp_if.ld_count) n_back++;
            if ((dp_if.ld_x || dp_if.ld_y) && dp_if.r_update) n_undo_rev++;
            if (dp_if.en_count) n_en++;
            if (dp_if.ld_x && dp_if.ld_y) n_viol++;
            if (dp_if.stack_dir_push && dp_if.stack_dir_pop) n_viol++;
            if (move_valid) begin
                n_mv++;
                if (exp_q.size() == 0) check("sb_extra_move", 32'(move_valid), 32'd0);
                else check("sb_move", 32'(m_lst[m_rd[8:0]]), 32'(exp_q.pop_front()));
            end
        end
    end

    logic w_any;
    assign w_any = |{dp_if.init_x, dp_if.init_y, dp_if.ld_x, dp_if.ld_y, dp_if.r_update,
                     dp_if.init_count, dp_if.ld_count, dp_if.en_count, dp_if.init_stack,
                     dp_if.stack_dir_push, dp_if.stack_dir_pop, dp_if.init_list,
                     dp_if.list_push, dp_if.en_read, dp_if.maze_wr, move_valid};

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic new_test();
        start = 1'b0;
        step();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_exp(input int n, input logic [1:0] code);
        for (int i = 0; i < n; i++) exp_q.push_back(code);
    endtask

    task automatic wait_end(input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < 3000 && !hit; i++) begin
            step();
            hit = done | fail;
        end
        if (!hit) check({tag, "_no_end"}, 32'd0, 32'd1);
    endtask

    task automatic clear_walls();
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                wall[i][j] = 1'b0;
    endtask

    initial begin
        clear_walls();
        step();
        step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_strobes", 32'(w_any), 32'd0);
        RST = 1'b1;
        step();
        check("idle_busy", 32'(busy), 32'd0);

`ifdef MAZE_CTRL_TIMEOUT_EN
        new_test();
        start = 1'b1;
        wait_end("tmo");
        check("tmo_fail", 32'(fail), 32'd1);
        check("tmo_flag", 32'(timeout), 32'd1);
        check("tmo_done", 32'(done), 32'd0);
        check("tmo_pushes", 32'(n_push), 32'd8);
        check("tmo_moves", 32'(n_mv), 32'd0);
        start = 1'b0;
        step();
        check("tmo_idle_fail", 32'(fail), 32'd0);
        check("tmo_idle_flag", 32'(timeout), 32'd0);
        check("tmo_idle_busy", 32'(busy), 32'd0);
`else
        // empty maze: 15 steps +Y then 15 steps +X, replayed newest first
        new_test();
        push_exp(15, 2'd1);
        push_exp(15, 2'd0);
        start = 1'b1;
        wait_end("empty");
        check("empty_done", 32'(done), 32'd1);
        check("empty_fail", 32'(fail), 32'd0);
        check("empty_moves", 32'(n_mv), 32'd30);
        check("empty_viol", 32'(n_viol), 32'd0);
        check("empty_sb_left", 32'(exp_q.size()), 32'd0);
        repeat (3) step();
        check("hold_done", 32'(done), 32'd1);
        check("hold_busy", 32'(busy), 32'd0);
        start = 1'b0;
        step();
        check("drop_done", 32'(done), 32'd0);
        check("drop_busy", 32'(busy), 32'd0);

        // restart: INIT must clear list and stack from the previous solve
        new_test();
        push_exp(15, 2'd1);
        push_exp(15, 2'd0);
        start = 1'b1;
        wait_end("again");
        check("again_done", 32'(done), 32'd1);
        check("again_moves", 32'(n_mv), 32'd30);
        check("again_sb_left", 32'(exp_q.size()), 32'd0);

        // walled start cell
        new_test();
        all_blocked = 1'b1;
        start = 1'b1;
        wait_end("wall");
        check("wall_fail", 32'(fail), 32'd1);
        check("wall_done", 32'(done), 32'd0);
        check("wall_en_count", 32'(n_en), 32'd3);
        check("wall_pushes", 32'(n_push), 32'd0);
        all_blocked = 1'b0;

        // dead-end corridor (0,1)..(0,3), detour via (1,0)
        new_test();
        wall[0][4] = 1'b1;
        wall[1][1] = 1'b1;
        wall[1][2] = 1'b1;
        wall[1][3] = 1'b1;
        push_exp(13, 2'd1);
        push_exp(15, 2'd0);
        push_exp(2, 2'd1);
        start = 1'b1;
        wait_end("dead");
        check("dead_done", 32'(done), 32'd1);
        check("dead_pre_back_push", 32'(n_push_pre), 32'd3);
        check("dead_backs", 32'(n_back), 32'd3);
        check("dead_undo_rev", 32'(n_undo_rev), 32'd3);
        check("dead_moves", 32'(n_mv), 32'd30);
        check("dead_viol", 32'(n_viol), 32'd0);
        check("dead_sb_left", 32'(exp_q.size()), 32'd0);
        clear_walls();

        // asynchronous reset while in MOVE
        new_test();
        start = 1'b1;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 50 && !hit; i++) begin
                step();
                hit = dp_if.stack_dir_push;
            end
            check("mid_reached_move", 32'(hit), 32'd1);
        end
        RST = 1'b0;
        #1;
        check("mid_strobes", 32'(w_any), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_move_valid", 32'(move_valid), 32'd0);
        RST = 1'b1;
        start = 1'b0;
        step();
        check("mid_after_busy", 32'(busy), 32'd0);
        check("mid_after_strobes", 32'(w_any), 32'd0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
